// File: rtl/bin2onehot_stim_if.sv
// Request/response bundle for the bin2onehot_stim tap decoder and sweeper.
// The master drives decode/sweep requests; the slave (the decoder) returns the tap pattern and status.
interface bin2onehot_stim_if #(
    parameter int WIDTH = 175,
    parameter int IDX_W = 8
);
    logic             start;
    logic [IDX_W-1:0] index_in;
    logic             index_valid;
    logic             index_ready;
    logic [WIDTH-1:0] one_hot;
    logic             one_hot_valid;
    logic [IDX_W-1:0] cur_index;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, index_in, index_valid,
        input  index_ready, one_hot, one_hot_valid, cur_index, busy, done, err
    );

    modport slave (
        input  start, index_in, index_valid,
        output index_ready, one_hot, one_hot_valid, cur_index, busy, done, err
    );
endinterface

// File: rtl/bin2onehot_stim.sv
// Binary tap index to registered one-hot delay-line pattern, plus an autonomous sweep across all taps.
// Define BIN2OH_THERMO_EN to emit a thermometer code (bits [index:0] set) instead of one-hot.
module bin2onehot_stim #(
    parameter int WIDTH = 175,
    parameter int IDX_W = 8,
    parameter int HOLD  = 4
) (
    input logic              clk,
    input logic              rst,
    bin2onehot_stim_if.slave bus
);

    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [WIDTH-1:0] FIRST_TAP = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
    logic [WIDTH-1:0] oneHot_q, oneHot_d;
    logic [IDX_W-1:0] curIndex_q, curIndex_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             indexReady;
    logic             inRange;
    logic [WIDTH-1:0] decoded;
    logic [WIDTH-1:0] shifted;

    assign indexReady = (state_q == IDLE) && !bus.start;
    assign inRange    = bus.index_in < IDX_W'(WIDTH);

    // Thermometer mode fills from bit 0; the subtraction only matters when inRange holds.
`ifdef BIN2OH_THERMO_EN
    assign decoded = {WIDTH{1'b1}} >> (IDX_W'(WIDTH - 1) - bus.index_in);
    assign shifted = {oneHot_q[WIDTH-2:0], 1'b1};
`else
    assign decoded = FIRST_TAP << bus.index_in;
    assign shifted = {oneHot_q[WIDTH-2:0], 1'b0};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            holdCnt_q  <= '0;
            oneHot_q   <= '0;
            curIndex_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            holdCnt_q  <= holdCnt_d;
            oneHot_q   <= oneHot_d;
            curIndex_q <= curIndex_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        holdCnt_d  = holdCnt_q;
        oneHot_d   = oneHot_q;
        curIndex_d = curIndex_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // start wins over a simultaneous decode request because index_ready drops with start.
                if (bus.start) begin
                    state_d    = SWEEP;
                    holdCnt_d  = '0;
                    oneHot_d   = FIRST_TAP;
                    curIndex_d = '0;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                end else if (bus.index_valid) begin
                    if (inRange) begin
                        oneHot_d   = decoded;
                        curIndex_d = bus.index_in;
                        valid_d    = 1'b1;
                    end else begin
                        oneHot_d = '0;
                        err_d    = 1'b1;
                    end
                end
            end

            SWEEP: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (holdCnt_q == CNT_W'(HOLD - 1)) begin
                    holdCnt_d = '0;
                    if (curIndex_q == IDX_W'(WIDTH - 1)) begin
                        state_d  = FINISH;
                        oneHot_d = '0;
                        valid_d  = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        curIndex_d = curIndex_q + IDX_W'(1);
                        oneHot_d   = shifted;
                    end
                end else begin
                    holdCnt_d = holdCnt_q + CNT_W'(1);
                end
            end

            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.index_ready   = indexReady;
    assign bus.one_hot       = oneHot_q;
    assign bus.one_hot_valid = valid_q;
    assign bus.cur_index     = curIndex_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;

endmodule
